// File: rtl/encode8to3_serial.sv
// Serial 8-to-3 encoder: reports every set bit of a captured vector as one index per beat.
// Build option: define ENC_MSB_FIRST_EN to report from bit 7 down to bit 0.
module encode8to3_serial #(
  parameter bit PASS_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_idx,
  output logic       out_last,
  output logic       out_zero
);

  typedef enum logic [0:0] {IDLE, EMIT} state_e;

  state_e     state_q;
  logic [7:0] pend_q, pend_d;
  logic       zflag_q;
  logic [2:0] idx_q;
  logic       last_q;
  logic       zero_q;

  // Index of the set bit reported next; the search direction is the only build difference.
  function automatic logic [2:0] sel_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) if (v[i]) idx = 3'(i);
`else
    for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
`endif
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  // Pending bits left after the currently presented beat is consumed.
  always_comb begin
    pend_d = pend_q & ~(8'h01 << idx_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 8'h00;
      zflag_q <= 1'b0;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_vec != 8'h00) begin
            state_q <= EMIT;
            pend_q  <= in_vec;
            zflag_q <= 1'b0;
            idx_q   <= sel_idx(in_vec);
            last_q  <= is_onehot(in_vec);
            zero_q  <= 1'b0;
          end else if (in_valid && PASS_ZERO) begin
            state_q <= EMIT;
            pend_q  <= 8'h00;
            zflag_q <= 1'b1;
            idx_q   <= 3'd0;
            last_q  <= 1'b1;
            zero_q  <= 1'b1;
          end
        end
        EMIT: begin
          // Outputs and pend only move on a transfer, so back-pressure holds the beat stable.
          if (out_ready) begin
            if (last_q) begin
              state_q <= IDLE;
              pend_q  <= 8'h00;
              zflag_q <= 1'b0;
              idx_q   <= 3'd0;
              last_q  <= 1'b0;
              zero_q  <= 1'b0;
            end else begin
              pend_q <= pend_d;
              idx_q  <= sel_idx(pend_d);
              last_q <= is_onehot(pend_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_encode8to3_serial.sv
// Directed bench for encode8to3_serial: one PASS_ZERO=1 instance plus a PASS_ZERO=0 instance
// sharing the same stimulus for the zero-vector drop case.
module tb_encode8to3_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;
  logic       in_ready, out_valid, out_last, out_zero;
  logic [2:0] out_idx;
  logic       nz_in_ready, nz_out_valid, nz_out_last, nz_out_zero;
  logic [2:0] nz_out_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  encode8to3_serial #(.PASS_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .out_zero(out_zero)
  );

  encode8to3_serial #(.PASS_ZERO(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nz_in_ready), .in_vec(in_vec),
    .out_valid(nz_out_valid), .out_ready(out_ready), .out_idx(nz_out_idx),
    .out_last(nz_out_last), .out_zero(nz_out_zero)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [2:0] idx, input logic last);
    check({tag, " valid"}, 8'(out_valid), 8'h1);
    check({tag, " idx"},   8'(out_idx),   8'(idx));
    check({tag, " last"},  8'(out_last),  8'(last));
    check({tag, " zero"},  8'(out_zero),  8'h0);
    check({tag, " ready"}, 8'(in_ready),  8'h0);
  endtask

  initial begin
    logic [2:0] ord_a5 [4];
    logic [2:0] ord_18 [2];
    logic [2:0] ord_03 [2];
    logic [2:0] ord_ff [2];
`ifdef ENC_MSB_FIRST_EN
    ord_a5 = '{3'd7, 3'd5, 3'd2, 3'd0};
    ord_18 = '{3'd4, 3'd3};
    ord_03 = '{3'd1, 3'd0};
    ord_ff = '{3'd7, 3'd6};
`else
    ord_a5 = '{3'd0, 3'd2, 3'd5, 3'd7};
    ord_18 = '{3'd3, 3'd4};
    ord_03 = '{3'd0, 3'd1};
    ord_ff = '{3'd0, 3'd1};
`endif

    rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst in_ready",  8'(in_ready),  8'h1);
    check("rst out_valid", 8'(out_valid), 8'h0);
    check("rst out_idx",   8'(out_idx),   8'h0);
    check("rst out_last",  8'(out_last),  8'h0);
    check("rst out_zero",  8'(out_zero),  8'h0);
    rst = 1'b0;

    // single set bit
    @(negedge clk);
    in_vec = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    beat("t1 b0", 3'd0, 1'b1);
    @(negedge clk);
    check("t1 bubble out_valid", 8'(out_valid), 8'h0);
    check("t1 in_ready",         8'(in_ready),  8'h1);

    // four bits, streamed back to back
    in_vec = 8'hA5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("t2 b%0d", i), ord_a5[i], 1'(i == 3));
      @(negedge clk);
    end
    check("t2 in_ready", 8'(in_ready), 8'h1);

    // back-pressure holds the first beat
    in_vec = 8'h18; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("t3 hold%0d", i), ord_18[0], 1'b0);
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    beat("t3 b1", ord_18[1], 1'b1);
    @(negedge clk);
    check("t3 in_ready", 8'(in_ready), 8'h1);

    // zero vector: emitted with PASS_ZERO=1, dropped with PASS_ZERO=0
    in_vec = 8'h00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t4 valid",       8'(out_valid),    8'h1);
    check("t4 idx",         8'(out_idx),      8'h0);
    check("t4 last",        8'(out_last),     8'h1);
    check("t4 zero",        8'(out_zero),     8'h1);
    check("t4 nz in_ready", 8'(nz_in_ready),  8'h1);
    check("t4 nz valid",    8'(nz_out_valid), 8'h0);
    @(negedge clk);
    check("t4 in_ready",    8'(in_ready),     8'h1);
    check("t4 after valid", 8'(out_valid),    8'h0);

    // reset mid-emit drops the remaining bits
    in_vec = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    beat("t5 b0", ord_ff[0], 1'b0);
    @(negedge clk);
    beat("t5 b1", ord_ff[1], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5 rst out_valid", 8'(out_valid), 8'h0);
    check("t5 rst in_ready",  8'(in_ready),  8'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5 no resume", 8'(out_valid), 8'h0);
    in_vec = 8'h40; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    beat("t5 b40", 3'd6, 1'b1);
    @(negedge clk);
    check("t5 in_ready", 8'(in_ready), 8'h1);

    // new vector presented during EMIT is ignored until in_ready returns
    in_vec = 8'h03; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_vec = 8'h80;
    beat("t6 b0", ord_03[0], 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    beat("t6 b1", ord_03[1], 1'b1);
    @(negedge clk);
    check("t6 in_ready", 8'(in_ready),  8'h1);
    check("t6 idle",     8'(out_valid), 8'h0);
    @(negedge clk);
    in_valid = 1'b0;
    beat("t6 b80", 3'd7, 1'b1);
    @(negedge clk);
    check("t6 end in_ready", 8'(in_ready), 8'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
